// File: rtl/shared_mem_responder_if.sv
// Shared-bus interface between the memory arbiter and the memory responder.
// Latency: no logic here; the responder registers read data one cycle after the address.
// Backpressure: none. The responder accepts one access per cycle.
//   shared_addr      byte address; bits [1:0] ignored
//   shared_write     write strobe; the write commits at the rising edge
//   shared_writedata write data
//   shared_readdata  registered read data
interface shared_mem_responder_if;
    logic [31:0] shared_addr;
    logic        shared_write;
    logic [31:0] shared_writedata;
    logic [31:0] shared_readdata;

    modport master (
        output shared_addr,
        output shared_write,
        output shared_writedata,
        input  shared_readdata
    );

    modport slave (
        input  shared_addr,
        input  shared_write,
        input  shared_writedata,
        output shared_readdata
    );
endinterface

// File: rtl/shared_mem_responder.sv
// Memory-side responder: word-addressed RAM plus a register window at addr[31:28]=4'hF.
// The window holds semaphores, a mailbox and performance counters.
// Latency: 1 cycle registered read, read-before-write on every location.
// Backpressure: none. One access per cycle is always accepted.
// Ports: i_clk (rising edge), i_rst (async active-high), bus (shared_mem_responder_if.slave).
// Optional feature: define SHARED_MEM_PERF_EN to build the cycle counter (0x100) and the
// RAM write counter (0x104). Without it, both offsets read 0 and behave as unmapped.
module shared_mem_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int NUM_SEMA  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    shared_mem_responder_if.slave   bus
);
    localparam int AW = $clog2(MEM_WORDS);

    // Word offsets inside the register window (byte offset >> 2).
    localparam logic [9:0] OFF_CYC   = 10'h040;
    localparam logic [9:0] OFF_WCNT  = 10'h041;
    localparam logic [9:0] OFF_MBDAT = 10'h042;
    localparam logic [9:0] OFF_MBSTS = 10'h043;

    logic [31:0] r_mem [MEM_WORDS];
    logic [31:0] r_sema [NUM_SEMA];
    logic [31:0] r_mb_data;
    logic        r_mb_full;
    logic        r_mb_ovf;
    logic [31:0] r_rdata;

    logic          w_win;
    logic [AW-1:0] w_idx;
    logic [9:0]    w_woff;
    logic          w_ram_we;
    logic          w_win_we;
    logic [31:0]   w_wd;
    logic [31:0]   w_cyc;
    logic [31:0]   w_wcnt;
    logic [31:0]   w_reg_rdata;
    logic          w_unused_ok;

    assign w_win    = (bus.shared_addr[31:28] == 4'hF);
    assign w_idx    = bus.shared_addr[AW+1:2];
    assign w_woff   = bus.shared_addr[11:2];
    assign w_wd     = bus.shared_writedata;
    assign w_ram_we = bus.shared_write & ~w_win;
    assign w_win_we = bus.shared_write & w_win;
    // Address bits that neither the RAM index nor the window offset look at.
    assign w_unused_ok = &{1'b0, bus.shared_addr[27:12], bus.shared_addr[1:0]};

`ifdef SHARED_MEM_PERF_EN
    logic [31:0] r_cyc;
    logic [31:0] r_wcnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cyc  <= 32'd0;
            r_wcnt <= 32'd0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
            if (w_ram_we) begin
                r_wcnt <= r_wcnt + 32'd1;
            end
        end
    end

    assign w_cyc  = r_cyc;
    assign w_wcnt = r_wcnt;
`else
    assign w_cyc  = 32'd0;
    assign w_wcnt = 32'd0;
`endif

    // Register window read mux; unmapped offsets fall through to 0.
    always_comb begin
        w_reg_rdata = 32'd0;
        for (int i = 0; i < NUM_SEMA; i++) begin
            if (w_woff == 10'(i)) begin
                w_reg_rdata = r_sema[i];
            end
        end
        case (w_woff)
            OFF_CYC:   w_reg_rdata = w_cyc;
            OFF_WCNT:  w_reg_rdata = w_wcnt;
            OFF_MBDAT: w_reg_rdata = r_mb_data;
            OFF_MBSTS: w_reg_rdata = {30'd0, r_mb_ovf, r_mb_full};
            default:   ;
        endcase
    end

    // RAM is never cleared. Writes seen while reset is high are dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_ram_we) begin
            r_mem[w_idx] <= w_wd;
        end
    end

    // Read data samples state before this edge's write, which gives read-before-write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= 32'd0;
        end else begin
            r_rdata <= w_win ? w_reg_rdata : r_mem[w_idx];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_SEMA; i++) begin
                r_sema[i] <= 32'd0;
            end
            r_mb_data <= 32'd0;
            r_mb_full <= 1'b0;
            r_mb_ovf  <= 1'b0;
        end else if (w_win_we) begin
            // Writing 0 releases unconditionally. Writing nonzero acquires only when free.
            for (int i = 0; i < NUM_SEMA; i++) begin
                if (w_woff == 10'(i)) begin
                    if (w_wd == 32'd0) begin
                        r_sema[i] <= 32'd0;
                    end else if (r_sema[i] == 32'd0) begin
                        r_sema[i] <= w_wd;
                    end
                end
            end
            if (w_woff == OFF_MBDAT) begin
                r_mb_data <= w_wd;
                r_mb_full <= 1'b1;
                if (r_mb_full) begin
                    r_mb_ovf <= 1'b1;
                end
            end
            if (w_woff == OFF_MBSTS) begin
                r_mb_full <= 1'b0;
                r_mb_ovf  <= 1'b0;
            end
        end
    end

    assign bus.shared_readdata = r_rdata;
endmodule

// File: tb/tb_shared_mem_responder.sv
// Randomized and directed bench for shared_mem_responder, with a behavioural model.
// Latency: the expected read data is the model value before each edge, checked 1 time unit after it.
// Backpressure: none; the bench issues one access per clock.
module tb_shared_mem_responder;
    localparam int MEM_WORDS = 1024;
    localparam int NUM_SEMA  = 4;
    localparam int AW        = $clog2(MEM_WORDS);
`ifdef SHARED_MEM_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst;
    shared_mem_responder_if bus();

    shared_mem_responder #(.MEM_WORDS(MEM_WORDS), .NUM_SEMA(NUM_SEMA)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    // Behavioural model state.
    logic [31:0] m_ram   [MEM_WORDS];
    bit          m_known [MEM_WORDS];
    logic [31:0] m_sema  [NUM_SEMA];
    logic [31:0] m_mb_data;
    bit          m_full, m_ovf;
    logic [31:0] m_cyc, m_wcnt;

    task automatic model_reset();
        for (int i = 0; i < NUM_SEMA; i++) m_sema[i] = 32'd0;
        m_mb_data = 32'd0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        m_cyc  = 32'd0;
        m_wcnt = 32'd0;
    endtask

    function automatic int word_idx(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    task automatic model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
        int off;
        v = 32'd0;
        known = 1'b1;
        off = int'(a[11:0]) / 4;
        if (a[31:28] != 4'hF) begin
            v = m_ram[word_idx(a)];
            known = m_known[word_idx(a)];
        end else if (off < NUM_SEMA) begin
            v = m_sema[off];
        end else if (off == 'h40) begin
            v = PERF ? m_cyc : 32'd0;
        end else if (off == 'h41) begin
            v = PERF ? m_wcnt : 32'd0;
        end else if (off == 'h42) begin
            v = m_mb_data;
        end else if (off == 'h43) begin
            v = {30'd0, m_ovf, m_full};
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic w, input logic [31:0] d);
        int off;
        off = int'(a[11:0]) / 4;
        m_cyc = m_cyc + 32'd1;
        if (!w) return;
        if (a[31:28] != 4'hF) begin
            m_ram[word_idx(a)] = d;
            m_known[word_idx(a)] = 1'b1;
            m_wcnt = m_wcnt + 32'd1;
        end else if (off < NUM_SEMA) begin
            if (d == 32'd0) m_sema[off] = 32'd0;
            else if (m_sema[off] == 32'd0) m_sema[off] = d;
        end else if (off == 'h42) begin
            if (m_full) m_ovf = 1'b1;
            m_full = 1'b1;
            m_mb_data = d;
        end else if (off == 'h43) begin
            m_full = 1'b0;
            m_ovf  = 1'b0;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: readdata=%h expected=%h", nm, act, exp);
        end
    endtask

    // One bus cycle: drive after the falling edge, check the model (and an optional literal) after the rising edge.
    task automatic step(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input bit lit_en, input logic [31:0] lit, input string nm);
        logic [31:0] exp;
        bit known;
        bus.shared_addr      = a;
        bus.shared_write     = w;
        bus.shared_writedata = d;
        model_read(a, exp, known);
        @(posedge clk);
        model_write(a, w, d);
        #1;
        if (known) check(nm, bus.shared_readdata, exp);
        if (lit_en) check({nm, "_lit"}, bus.shared_readdata, lit);
        @(negedge clk);
        bus.shared_write = 1'b0;
    endtask

    initial begin
        logic [31:0] a, d;
        logic [AW-1:0] idx;
        logic [9:0] w;
        int r;

        for (int i = 0; i < MEM_WORDS; i++) m_known[i] = 1'b0;
        model_reset();
        rst = 1'b1;
        bus.shared_addr = 32'd0;
        bus.shared_write = 1'b0;
        bus.shared_writedata = 32'd0;
        repeat (3) @(posedge clk);
        #1 check("reset_rdata", bus.shared_readdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Counters: 10 idle edges, 3 RAM writes and 1 register write.
        for (int i = 0; i < 10; i++) step(32'hF000_0200, 1'b0, 32'd0, 1'b1, 32'd0, "idle_unmapped");
        step(32'h0000_0100, 1'b1, 32'h1, 1'b0, 32'd0, "perf_wr0");
        step(32'h0000_0104, 1'b1, 32'h2, 1'b0, 32'd0, "perf_wr1");
        step(32'h0000_0108, 1'b1, 32'h3, 1'b0, 32'd0, "perf_wr2");
        step(32'hF000_010C, 1'b1, 32'hFFFF, 1'b0, 32'd0, "perf_regwr");
        step(32'hF000_0104, 1'b0, 32'd0, 1'b1, PERF ? 32'd3 : 32'd0, "wcnt");
        step(32'hF000_0100, 1'b0, 32'd0, 1'b1, PERF ? 32'd15 : 32'd0, "cyc");

        // RAM write and aliasing.
        step(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0, "ram_wr");
        step(32'h0000_0010, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF, "ram_rd");
        step(32'h0000_1010, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF, "ram_alias");
        step(32'h0000_0014, 1'b0, 32'd0, 1'b0, 32'd0, "ram_rd14");
        tests++;
        if (bus.shared_readdata === 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL ram_neighbour: readdata=%h must differ from deadbeef", bus.shared_readdata);
        end

        // Read-before-write.
        step(32'h0000_0020, 1'b1, 32'h11, 1'b0, 32'd0, "rbw_init");
        step(32'h0000_0020, 1'b1, 32'h22, 1'b1, 32'h11, "rbw_old");
        step(32'h0000_0020, 1'b0, 32'd0, 1'b1, 32'h22, "rbw_new");

        // Semaphores.
        step(32'hF000_0000, 1'b1, 32'hA, 1'b0, 32'd0, "sem_acq_a");
        step(32'hF000_0000, 1'b1, 32'hB, 1'b1, 32'hA, "sem_try_b");
        step(32'hF000_0000, 1'b0, 32'd0, 1'b1, 32'hA, "sem_held");
        step(32'hF000_0000, 1'b1, 32'h0, 1'b0, 32'd0, "sem_rel");
        step(32'hF000_0000, 1'b0, 32'd0, 1'b1, 32'h0, "sem_free");
        step(32'hF000_0000, 1'b1, 32'hB, 1'b0, 32'd0, "sem_acq_b");
        step(32'hF000_0000, 1'b0, 32'd0, 1'b1, 32'hB, "sem_b");
        step(32'hF000_000C, 1'b0, 32'd0, 1'b1, 32'h0, "sem3");

        // Mailbox.
        step(32'hF000_0108, 1'b1, 32'h55, 1'b0, 32'd0, "mb_wr55");
        step(32'hF000_010C, 1'b0, 32'd0, 1'b1, 32'h1, "mb_full");
        step(32'hF000_0108, 1'b1, 32'h66, 1'b0, 32'd0, "mb_wr66");
        step(32'hF000_010C, 1'b0, 32'd0, 1'b1, 32'h3, "mb_ovf");
        step(32'hF000_0108, 1'b0, 32'd0, 1'b1, 32'h66, "mb_data");
        step(32'hF000_010C, 1'b1, 32'h1234, 1'b0, 32'd0, "mb_clr");
        step(32'hF000_010C, 1'b0, 32'd0, 1'b1, 32'h0, "mb_empty");

        // Randomized traffic over a small RAM footprint and the whole register window.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                a = $urandom;
                if (a[31:28] == 4'hF) a[31:28] = 4'h0;
                idx = AW'($urandom_range(0, 15));
                a[AW+1:2] = idx;
                d = $urandom;
            end else begin
                r = $urandom_range(0, 9);
                w = (r < 6) ? 10'(r) : 10'(r - 6 + 'h40);
                a = {4'hF, 16'($urandom), w, 2'($urandom)};
                d = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 3));
            end
            step(a, 1'($urandom_range(0, 1)), d, 1'b0, 32'd0, "random");
        end

        // Reset asserted in the middle of a RAM write.
        step(32'h0000_0040, 1'b1, 32'h77, 1'b0, 32'd0, "rst_prep");
        step(32'h0000_0040, 1'b0, 32'd0, 1'b1, 32'h77, "rst_prep_rd");
        bus.shared_addr      = 32'h0000_0040;
        bus.shared_write     = 1'b1;
        bus.shared_writedata = 32'h99;
        #2 rst = 1'b1;
        #1 check("rst_async_rdata", bus.shared_readdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 check("rst_hold_rdata", bus.shared_readdata, 32'd0);
        @(negedge clk);
        bus.shared_write = 1'b0;
        rst = 1'b0;
        model_reset();
        step(32'h0000_0040, 1'b0, 32'd0, 1'b1, 32'h77, "rst_ram_kept");
        step(32'hF000_0000, 1'b0, 32'd0, 1'b1, 32'h0, "rst_sem");
        step(32'hF000_010C, 1'b0, 32'd0, 1'b1, 32'h0, "rst_mb_sts");
        step(32'hF000_0108, 1'b0, 32'd0, 1'b1, 32'h0, "rst_mb_data");
        step(32'hF000_0104, 1'b0, 32'd0, 1'b1, 32'h0, "rst_wcnt");
        step(32'hF000_0100, 1'b0, 32'd0, 1'b1, PERF ? 32'd5 : 32'd0, "rst_cyc");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
